// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the register block between two
//   writeback requesters. The winning write is registered onto
//   RegWrite/WriteReg/WriteData. A pending-write scoreboard tracks which
//   registers have an outstanding producer, so that decode can stall on
//   read-after-write hazards.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req0_valid/reg/data, req0_ready ALU writeback request and its accept
//   req1_valid/reg/data, req1_ready multi-cycle/load request and its accept
//   issue_valid, issue_reg          destination of the issuing instruction
//   rd_reg1, rd_reg2                decode source registers
//   stall                           source hazard on a busy register
//   busy                            pending-write bit per register
//   RegWrite, WriteReg, WriteData   write port of the register block
module regfile_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_reg,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_reg,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  input  logic [ADDR_W-1:0]      rd_reg1,
  input  logic [ADDR_W-1:0]      rd_reg2,
  output logic                   stall,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteReg,
  output logic [DATA_W-1:0]      WriteData
);

  localparam int NREG = 2**ADDR_W;

  // 1 = req1 was granted most recently; resets to 1 so req0 wins the first tie
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_next;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (RR_MODE) begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_reg    = grant1 ? req1_reg  : req0_reg;
  assign sel_data   = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      last_grant <= 1'b1;
    end else begin
      // A write to register 0 completes the handshake but never reaches the block.
      RegWrite <= accept && (sel_reg != '0);
      if (accept) begin
        WriteReg   <= sel_reg;
        WriteData  <= sel_data;
        last_grant <= grant1;
      end
    end
  end

  // Clear happens on the commit edge; a same-edge issue to the same register
  // is applied afterwards so the newer producer stays outstanding.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[WriteReg] = 1'b0;
    if (issue_valid && (issue_reg != '0)) busy_next[issue_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign stall = ((rd_reg1 != '0) && busy[rd_reg1]) ||
                 ((rd_reg2 != '0) && busy[rd_reg2]);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8 x 32-bit register block between two writeback requesters: req0 (ALU writeback) and req1 (multi-cycle/load unit).
- Registers the winning write onto RegWrite/WriteReg/WriteData.
- Keeps a pending-write scoreboard so decode can stall on read-after-write hazards against either producer.
- Sits between the execute/writeback units and the register block.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 3, register index width (8 registers)
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  req0 has a write pending
- req0_reg  input  ADDR_W  req0 destination register
- req0_data  input  DATA_W  req0 write data
- req0_ready  output  1  req0 accepted this cycle (combinational)
- req1_valid  input  1  req1 has a write pending
- req1_reg  input  ADDR_W  req1 destination register
- req1_data  input  DATA_W  req1 write data
- req1_ready  output  1  req1 accepted this cycle (combinational)
- issue_valid  input  1  an instruction with a destination issues this cycle
- issue_reg  input  ADDR_W  destination of the issuing instruction
- rd_reg1  input  ADDR_W  decode source register 1
- rd_reg2  input  ADDR_W  decode source register 2
- stall  output  1  source hazard on a busy register (combinational)
- busy  output  2^ADDR_W  pending-write bit per register
- RegWrite  output  1  to register block
- WriteReg  output  ADDR_W  to register block
- WriteData  output  DATA_W  to register block

Behaviour:
Interface and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, busy=0, last_grant=1 (so req0 wins the first tie).
- Reset mid-operation drops any registered write and clears all busy bits. No write is issued in the cycle following reset deassertion unless a request is accepted in that cycle.

Handshake:
- A request is accepted in cycle N when its valid and ready are both 1.
- At most one ready is high per cycle. A ready is never high without its valid.
- Requesters hold valid, reg and data stable until accepted.

Arbitration:
- Only one valid: that requester is granted.
- Both valid, RR_MODE=1: grant the requester that was not granted last. last_grant updates on every acceptance.
- Both valid, RR_MODE=0: req0 is granted and req1 waits.
- Round-robin bound: a waiting requester is accepted within 2 cycles.

Write path (1-cycle latency):
- A request accepted in cycle N drives RegWrite=1 and the latched WriteReg/WriteData during cycle N+1. The register block commits on the rising edge ending N+1.
- With no acceptance, RegWrite=0 next cycle; WriteReg/WriteData hold their last values.
- A request to register 0 completes the handshake but drives RegWrite=0; register 0 is never written.

Scoreboard:
- Set: issue_valid=1 with issue_reg!=0 sets busy[issue_reg] at the clock edge.
- Clear: busy[WriteReg] clears on the edge where RegWrite=1, i.e. the commit edge, not the accept edge.
- Set and clear of the same register on the same edge: set wins, because a newer producer is outstanding.
- busy[0] is always 0.

Hazard detection:
- stall = (rd_reg1!=0 && busy[rd_reg1]) || (rd_reg2!=0 && busy[rd_reg2]).
- No forwarding is provided. A reader sees committed data the cycle after busy clears.

Test Plan:
- Reset: assert rst_n=0 with both valid high -> ready 0/0, RegWrite=0, busy=0; release rst_n -> req0 accepted first.
- Single request: req0 reg=3, data=0xDEADBEEF in cycle 1 -> req0_ready=1 in cycle 1; cycle 2 shows RegWrite=1, WriteReg=3, WriteData=0xDEADBEEF.
- Contention, RR_MODE=1: both valid for 4 cycles -> grants alternate 0,1,0,1 and WriteReg follows the same order one cycle later. RR_MODE=0: req0 is granted every cycle and req1_ready stays 0.
- Scoreboard: issue reg=5 -> busy[5]=1, and stall=1 for rd_reg1=5. req1 writes reg 5 -> busy[5] clears on the commit edge; stall=0 the cycle after. Same-edge issue of reg 5 with commit of reg 5 -> busy[5] stays 1.
- Register 0: req0 reg=0, data=0x1234 -> accepted, RegWrite stays 0; issue reg=0 -> busy unchanged; rd_reg1=0 -> stall=0.
- Async reset mid-write: drop rst_n while RegWrite=1 between clock edges -> RegWrite=0 and busy=0 immediately, without waiting for a clock edge.
